// File: rtl/multi_collider.sv
// multi_collider
//   Frame-accumulating terrain collider for N_OBJ objects checked in parallel.
//   The renderer sweeps one terrain column (one bit per row, 1 = solid) per
//   col_valid. Each object collects sticky landed/bounce/impact flags over the
//   frame. At the next frame_start those flags are published to game logic
//   through a valid/ready handshake.
//
//   Optional build macro: COLLIDER_SIDE_SPLIT_EN
//     When defined, adds impact_l/impact_r outputs that separate the left
//     side probe from the right side probe. impact is always impact_l | impact_r.
//
// Ports
//   clk           system clock
//   reset         asynchronous reset, active-low
//   frame_start   single-cycle pulse that starts a new sweep
//   col_valid     DrawX/terrain_data carry a column this cycle
//   DrawX         column index of terrain_data
//   terrain_data  column bitmap, bit r = row r
//   obj_en        per-object enable (disabled objects never raise flags)
//   obj_x/y/r     packed object centre X, centre Y and radius; object i at [i*CW +: CW]
//   res_valid     published flags valid
//   res_ready     consumer accepts the published flags
//   landed        bottom probe hit
//   bounce        top probe hit without a bottom hit
//   impact        side probe hit
//   impact_l/r    left/right side probe hits (COLLIDER_SIDE_SPLIT_EN only)
//   overrun       sticky: a frame was published while the previous one was unread
module multi_collider #(
  parameter int N_OBJ     = 4,
  parameter int TERRAIN_H = 512,
  parameter int CW        = 10,
  parameter int SIDE_OFS  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  col_valid,
  input  logic [CW-1:0]         DrawX,
  input  logic [TERRAIN_H-1:0]  terrain_data,
  input  logic [N_OBJ-1:0]      obj_en,
  input  logic [N_OBJ*CW-1:0]   obj_x,
  input  logic [N_OBJ*CW-1:0]   obj_y,
  input  logic [N_OBJ*CW-1:0]   obj_r,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [N_OBJ-1:0]      landed,
  output logic [N_OBJ-1:0]      bounce,
  output logic [N_OBJ-1:0]      impact,
`ifdef COLLIDER_SIDE_SPLIT_EN
  output logic [N_OBJ-1:0]      impact_l,
  output logic [N_OBJ-1:0]      impact_r,
`endif
  output logic                  overrun
);

  localparam logic [CW:0] OFS = (CW+1)'(SIDE_OFS);

  typedef enum logic [0:0] {IDLE, SCAN} state_t;

  state_t state_q, state_d;

  logic [N_OBJ-1:0] hit_land, hit_bounce, hit_l, hit_r;
  logic [N_OBJ-1:0] land_acc, bounce_acc, l_acc, r_acc;
  logic [N_OBJ-1:0] impact_l_q, impact_r_q;

  logic [CW:0] draw_ext, probe_l, probe_r;
  logic        probe_r_ok, scan_col, publish;
  logic [CW:0] cx, cy, cr, y_plus_r;
  logic        bot_bit, top_bit, side_bit;

  // Reads one row of the column. Rows past the top of the bitmap shift out
  // and therefore read as empty.
  function automatic logic tbit(input logic [TERRAIN_H-1:0] col, input logic [CW:0] row);
    logic [TERRAIN_H-1:0] s;
    s = col >> row;
    return s[0];
  endfunction

  // All probe arithmetic uses one extra bit, so DrawX +/- SIDE_OFS never
  // wraps onto a real column.
  assign draw_ext   = {1'b0, DrawX};
  assign probe_l    = draw_ext + OFS;
  assign probe_r    = draw_ext - OFS;
  assign probe_r_ok = (draw_ext >= OFS);
  assign scan_col   = col_valid && (state_q == SCAN);
  assign publish    = frame_start && (state_q == SCAN);

  // Per-object hits for the current column. Outside SCAN the hits are forced
  // to zero, so frame_start in IDLE simply clears the accumulators.
  always_comb begin
    hit_land   = '0;
    hit_bounce = '0;
    hit_l      = '0;
    hit_r      = '0;
    cx = '0; cy = '0; cr = '0; y_plus_r = '0;
    bot_bit = 1'b0; top_bit = 1'b0; side_bit = 1'b0;
    for (int i = 0; i < N_OBJ; i++) begin
      cx       = {1'b0, obj_x[i*CW +: CW]};
      cy       = {1'b0, obj_y[i*CW +: CW]};
      cr       = {1'b0, obj_r[i*CW +: CW]};
      y_plus_r = cy + cr;
      // Below the bitmap is treated as floor; above row 0 is open sky.
      bot_bit  = (32'(y_plus_r) >= 32'(TERRAIN_H)) ? 1'b1 : tbit(terrain_data, y_plus_r);
      top_bit  = (cy < cr) ? 1'b0 : tbit(terrain_data, cy - cr);
      side_bit = (32'(cy) >= 32'(TERRAIN_H)) ? 1'b0 : tbit(terrain_data, cy);
      if (scan_col && obj_en[i]) begin
        if (cx == draw_ext) begin
          hit_land[i]   = bot_bit;
          hit_bounce[i] = !bot_bit && top_bit;
        end
        if (cx == probe_l) hit_l[i] = side_bit;
        if (probe_r_ok && (cx == probe_r)) hit_r[i] = side_bit;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: the first frame_start arms scanning. After that, only reset
  // returns the block to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_start) state_d = SCAN;
      SCAN:    state_d = SCAN;
      default: state_d = IDLE;
    endcase
  end

  // Sticky accumulators. On frame_start they restart from the current column's
  // hits, so a column that arrives together with frame_start counts toward the
  // new frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      land_acc   <= '0;
      bounce_acc <= '0;
      l_acc      <= '0;
      r_acc      <= '0;
    end else if (frame_start) begin
      land_acc   <= hit_land;
      bounce_acc <= hit_bounce;
      l_acc      <= hit_l;
      r_acc      <= hit_r;
    end else begin
      land_acc   <= land_acc | hit_land;
      bounce_acc <= bounce_acc | hit_bounce;
      l_acc      <= l_acc | hit_l;
      r_acc      <= r_acc | hit_r;
    end
  end

  // Published results and handshake. A publish on the same edge as a consume
  // keeps res_valid high with the new data. A publish over unread data sets
  // overrun, which clears only on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      landed     <= '0;
      bounce     <= '0;
      impact_l_q <= '0;
      impact_r_q <= '0;
      res_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else if (publish) begin
      landed     <= land_acc;
      bounce     <= bounce_acc;
      impact_l_q <= l_acc;
      impact_r_q <= r_acc;
      res_valid  <= 1'b1;
      if (res_valid && !res_ready) overrun <= 1'b1;
    end else if (res_valid && res_ready) begin
      res_valid  <= 1'b0;
    end
  end

  assign impact = impact_l_q | impact_r_q;

`ifdef COLLIDER_SIDE_SPLIT_EN
  assign impact_l = impact_l_q;
  assign impact_r = impact_r_q;
`endif

endmodule

// File: tb/tb_multi_collider.sv
// tb_multi_collider
//   Directed test of multi_collider with the default parameters. Each step
//   drives one cycle of inputs and then compares the published outputs with
//   hand-computed values.
module tb_multi_collider;

  localparam int N_OBJ = 4;
  localparam int TH    = 512;
  localparam int CW    = 10;

  logic                 clk;
  logic                 reset;
  logic                 frame_start;
  logic                 col_valid;
  logic [CW-1:0]        DrawX;
  logic [TH-1:0]        terrain_data;
  logic [N_OBJ-1:0]     obj_en;
  logic [N_OBJ*CW-1:0]  obj_x, obj_y, obj_r;
  logic                 res_valid;
  logic                 res_ready;
  logic [N_OBJ-1:0]     landed, bounce, impact;
`ifdef COLLIDER_SIDE_SPLIT_EN
  logic [N_OBJ-1:0]     impact_l, impact_r;
`endif
  logic                 overrun;

  int checks = 0;
  int errors = 0;

  multi_collider #(.N_OBJ(N_OBJ), .TERRAIN_H(TH), .CW(CW), .SIDE_OFS(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .col_valid    (col_valid),
    .DrawX        (DrawX),
    .terrain_data (terrain_data),
    .obj_en       (obj_en),
    .obj_x        (obj_x),
    .obj_y        (obj_y),
    .obj_r        (obj_r),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .landed       (landed),
    .bounce       (bounce),
    .impact       (impact),
`ifdef COLLIDER_SIDE_SPLIT_EN
    .impact_l     (impact_l),
    .impact_r     (impact_r),
`endif
    .overrun      (overrun)
  );

  // Free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  function automatic logic [TH-1:0] rows(input int a, input int b);
    logic [TH-1:0] r;
    r = '0;
    if (a >= 0) r[a] = 1'b1;
    if (b >= 0) r[b] = 1'b1;
    return r;
  endfunction

  task automatic set_obj(input int i, input int x, input int y, input int r);
    obj_x[i*CW +: CW] = CW'(x);
    obj_y[i*CW +: CW] = CW'(y);
    obj_r[i*CW +: CW] = CW'(r);
  endtask

  // One clock of stimulus. Outputs are then stable 1 time unit after the edge.
  task automatic apply_stimulus(input logic fs, input logic cv, input int dx, input logic [TH-1:0] td);
    frame_start  = fs;
    col_valid    = cv;
    DrawX        = CW'(dx);
    terrain_data = td;
    @(posedge clk);
    #1;
    frame_start  = 1'b0;
    col_valid    = 1'b0;
    terrain_data = '0;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag, input logic v, input logic [N_OBJ-1:0] l,
                              input logic [N_OBJ-1:0] b, input logic [N_OBJ-1:0] im, input logic ov);
    check_val({tag, ".res_valid"}, 32'(res_valid), 32'(v));
    check_val({tag, ".landed"},    32'(landed),    32'(l));
    check_val({tag, ".bounce"},    32'(bounce),    32'(b));
    check_val({tag, ".impact"},    32'(impact),    32'(im));
    check_val({tag, ".overrun"},   32'(overrun),   32'(ov));
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b0;
    frame_start = 1'b0;
    col_valid = 1'b0;
    DrawX = '0;
    terrain_data = '0;
    obj_en = 4'b0001;
    obj_x = '0; obj_y = '0; obj_r = '0;
    res_ready = 1'b1;
    set_obj(0, 100, 200, 5);

    repeat (2) @(posedge clk);
    #1;
    check_output("reset", 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    reset = 1'b1;

    // Reset in the middle of SCAN with an accumulated hit
    apply_stimulus(1'b1, 1'b0, 0, '0);
    apply_stimulus(1'b0, 1'b1, 100, rows(205, -1));
    reset = 1'b0;
    #1;
    check_output("mid_reset", 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    reset = 1'b1;
    apply_stimulus(1'b0, 1'b1, 100, rows(205, -1));
    apply_stimulus(1'b1, 1'b0, 0, '0);
    check_val("idle_fs_no_publish", 32'(res_valid), 32'd0);
    apply_stimulus(1'b1, 1'b0, 0, '0);
    check_output("idle_col_ignored", 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    apply_stimulus(1'b0, 1'b0, 0, '0);
    check_val("consume_drop", 32'(res_valid), 32'd0);

    // Bottom probe hit on object 0
    apply_stimulus(1'b0, 1'b1, 100, rows(205, -1));
    apply_stimulus(1'b1, 1'b0, 0, '0);
    check_output("landed", 1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0);

    // Top and bottom probes both solid: landed wins
    apply_stimulus(1'b0, 1'b1, 100, rows(195, 205));
    apply_stimulus(1'b1, 1'b0, 0, '0);
    check_output("land_over_bounce", 1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0);

    // Top probe only
    apply_stimulus(1'b0, 1'b1, 100, rows(195, -1));
    apply_stimulus(1'b1, 1'b0, 0, '0);
    check_output("bounce", 1'b1, 4'b0000, 4'b0001, 4'b0000, 1'b0);

    // Side probes at DrawX = x-4 and x+4
    apply_stimulus(1'b0, 1'b1, 96, rows(200, -1));
    apply_stimulus(1'b1, 1'b0, 0, '0);
    check_output("impact_96", 1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    apply_stimulus(1'b0, 1'b1, 104, rows(200, -1));
    apply_stimulus(1'b1, 1'b0, 0, '0);
    check_output("impact_104", 1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    apply_stimulus(1'b0, 1'b0, 0, '0);

    // Boundary probes on object 1 (object 0 disabled)
    obj_en = 4'b0010;
    set_obj(1, 300, 5, 5);
    apply_stimulus(1'b0, 1'b1, 300, rows(0, -1));
    apply_stimulus(1'b1, 1'b0, 0, '0);
    check_output("top_row0", 1'b1, 4'b0000, 4'b0010, 4'b0000, 1'b0);
    set_obj(1, 300, 3, 5);
    apply_stimulus(1'b0, 1'b1, 300, rows(0, -1));
    apply_stimulus(1'b1, 1'b0, 0, '0);
    check_output("open_sky", 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    set_obj(1, 300, 510, 5);
    apply_stimulus(1'b0, 1'b1, 300, '0);
    apply_stimulus(1'b1, 1'b0, 0, '0);
    check_output("floor", 1'b1, 4'b0010, 4'b0000, 4'b0000, 1'b0);
    set_obj(1, 2, 200, 0);
    apply_stimulus(1'b0, 1'b1, 1022, rows(200, -1));
    apply_stimulus(1'b1, 1'b0, 0, '0);
    check_output("ofs_no_wrap", 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    set_obj(1, 4, 200, 0);
    apply_stimulus(1'b0, 1'b1, 0, rows(200, -1));
    apply_stimulus(1'b1, 1'b0, 0, '0);
    check_output("ofs_low_edge", 1'b1, 4'b0000, 4'b0000, 4'b0010, 1'b0);
    apply_stimulus(1'b0, 1'b0, 0, '0);

    // Overrun: consumer stalls across two publishes
    obj_en = 4'b0001;
    res_ready = 1'b0;
    apply_stimulus(1'b0, 1'b1, 100, rows(205, -1));
    apply_stimulus(1'b1, 1'b0, 0, '0);
    check_output("ovr_first", 1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    apply_stimulus(1'b0, 1'b1, 100, rows(195, -1));
    check_output("ovr_hold", 1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    apply_stimulus(1'b1, 1'b0, 0, '0);
    check_output("ovr_second", 1'b1, 4'b0000, 4'b0001, 4'b0000, 1'b1);
    apply_stimulus(1'b0, 1'b1, 96, rows(200, -1));
    res_ready = 1'b1;
    apply_stimulus(1'b1, 1'b0, 0, '0);
    check_output("same_edge_publish", 1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b1);
    apply_stimulus(1'b0, 1'b0, 0, '0);
    check_val("drop_after_consume", 32'(res_valid), 32'd0);

    // A column that arrives with frame_start belongs to the new frame
    apply_stimulus(1'b0, 1'b1, 100, rows(205, -1));
    apply_stimulus(1'b1, 1'b1, 104, rows(200, -1));
    check_output("fs_col_old", 1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    apply_stimulus(1'b1, 1'b0, 0, '0);
    check_output("fs_col_new", 1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b1);
    apply_stimulus(1'b0, 1'b0, 0, '0);
    check_output("sticky_overrun", 1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
